tdm_demux_rx: RTL



---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_slot_counter.sv | 35 +++
 rtl/tdm_demux_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM mux path (transmitter and receiver).
package tdm_pkg;

    // Receiver frame state: no frame open, or partial frame held.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_t;

    // Slot index width for a given lane count; a single lane still gets one bit.
    function automatic int sel_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index register with clear / load-1 / increment and a last-slot flag.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int SELW  = sel_width(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load1,
    input  logic            inc,
    output logic [SELW-1:0] slot,
    output logic            last_slot
);

    logic [SELW-1:0] slot_reg;

    // Slot register; clear wins over load-1, which wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg <= '0;
        end else if (clr) begin
            slot_reg <= '0;
        end else if (load1) begin
            slot_reg <= SELW'(1);
        end else if (inc) begin
            slot_reg <= slot_reg + SELW'(1);
        end
    end

    assign slot      = slot_reg;
    assign last_slot = (slot_reg == SELW'(WIDTH - 1));

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receive demux: steers serial slot bits into lanes and presents whole words.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int SELW  = sel_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             frame_start,
    input  logic             y_in,
    output logic [SELW-1:0]  sel_out,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic             frame_err,
    output logic             busy
);

    tdm_state_t       state_reg, state_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
    logic [WIDTH-1:0] d_out_reg, d_out_next;
    logic             d_valid_reg, d_valid_next;
    logic             frame_err_reg, frame_err_next;

    logic             slot_clr, slot_load1, slot_inc;
    logic [SELW-1:0]  slot;
    logic             last_slot;
    logic [SELW-1:0]  write_idx;
    logic [WIDTH-1:0] merged_word;
    logic             complete;

    tdm_slot_counter #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .clr       (slot_clr),
        .load1     (slot_load1),
        .inc       (slot_inc),
        .slot      (slot),
        .last_slot (last_slot)
    );

    // A frame-start bit always lands in lane 0; otherwise the current slot's lane.
    always_comb begin
        write_idx = '0;
        if (state_reg == COLLECT && !frame_start) begin
            write_idx = slot;
        end
    end

    // Shadow word with the current bit merged in, so completion uses the same-cycle bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign merged_word[gi] = (write_idx == SELW'(gi)) ? y_in : shadow_reg[gi];
        end
    endgenerate

    // Next-state, shadow capture, completion and error pulse decisions.
    always_comb begin
        state_next     = state_reg;
        shadow_next    = shadow_reg;
        d_out_next     = d_out_reg;
        d_valid_next   = 1'b0;
        frame_err_next = 1'b0;
        slot_clr       = 1'b0;
        slot_load1     = 1'b0;
        slot_inc       = 1'b0;
        complete       = 1'b0;

        if (in_valid) begin
            unique case (state_reg)
                IDLE: begin
                    // Bits without frame_start are strays and are dropped silently.
                    if (frame_start) begin
                        shadow_next = merged_word;
                        if (WIDTH == 1) begin
                            complete = 1'b1;
                        end else begin
                            slot_load1 = 1'b1;
                            state_next = COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    shadow_next = merged_word;
                    if (frame_start) begin
                        // Early start: drop the partial frame and resync on this bit.
                        frame_err_next = 1'b1;
                        if (WIDTH == 1) begin
                            complete = 1'b1;
                        end else begin
                            slot_load1 = 1'b1;
                        end
                    end else if (last_slot) begin
                        complete = 1'b1;
                    end else begin
                        slot_inc = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (complete) begin
            d_out_next   = merged_word;
            d_valid_next = 1'b1;
            slot_clr     = 1'b1;
            state_next   = IDLE;
        end
    end

    // State, shadow word and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            shadow_reg    <= '0;
            d_out_reg     <= '0;
            d_valid_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shadow_reg    <= shadow_next;
            d_out_reg     <= d_out_next;
            d_valid_reg   <= d_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign sel_out   = slot;
    assign d_out     = d_out_reg;
    assign d_valid   = d_valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg == COLLECT);

endmodule
